nn_conv2_seq: RTL and testbench

- Parametrised, sequential two-layer 3x3 convolution engine.
- Generalises the fixed two-stage 12x12 → 10x10 → 8x8 network with configurable image size, pixel width, first-layer filter count and second-layer fan-out, plus signed weights, right-shift requantisation with ReLU clamp, and a start/busy/done handshake.
- Computes one 3x3 window per clock, so NF1 + NF1·NF2 maps cost one MAC datapath instead of one PE array per map.
- Sits between the image loader and the classifier/readout logic.

---
 rtl/nn_conv2_seq.sv | 171 +++++++++++++++++
 tb/tb_nn_conv2_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_conv2_seq.sv
// nn_conv2_seq: two-layer 3x3 convolution engine that computes one window per clock on a single MAC datapath.
// Latency: start is sampled at edge 0, busy is high after edges 1..N1+N2, and done pulses after edge N1+N2+1.
// Backpressure: no queueing. start is taken only in IDLE/DONE and ignored otherwise. rst aborts a run on any edge.
//
// Ports: clk, rst (sync, active-high), start; in = IMG*IMG unsigned pixels; w1 = NF1 signed 3x3
//        filters; w2 = NF1*NF2 signed 3x3 filters; busy, done; out = NF1*NF2 maps of O2*O2 pixels.
// Optional feature: define NN_ROUND_EN to round half up before the requantisation shift.
module nn_conv2_seq #(
  parameter int IMG   = 12,
  parameter int DW    = 2,
  parameter int NF1   = 2,
  parameter int NF2   = 2,
  parameter int SHIFT = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [IMG*IMG*DW-1:0]                  in,
  input  logic [NF1*9*DW-1:0]                    w1,
  input  logic [NF1*NF2*9*DW-1:0]                w2,
  output logic                                   busy,
  output logic                                   done,
  output logic [NF1*NF2*(IMG-4)*(IMG-4)*DW-1:0]  out
);
  localparam int O1   = IMG - 2;
  localparam int O2   = IMG - 4;
  localparam int ACCW = 2 * DW + 5;
  localparam int NM2  = NF1 * NF2;
  localparam int MW   = $clog2(NM2 + 1);
  localparam int RW   = $clog2(O1 + 1);
  localparam logic [RW-1:0] O1_LAST = RW'(O1 - 1);
  localparam logic [RW-1:0] O2_LAST = RW'(O2 - 1);
  localparam logic [MW-1:0] M1_LAST = MW'(NF1 - 1);
  localparam logic [MW-1:0] M2_LAST = MW'(NM2 - 1);
  localparam logic signed [ACCW:0] MAXV = (ACCW+1)'((1 << DW) - 1);
`ifdef NN_ROUND_EN
  // Half an LSB of the shifted result; this is zero when SHIFT is 0.
  localparam logic signed [ACCW:0] RND = (ACCW+1)'((1 << SHIFT) >> 1);
`endif

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_L1, S_L2, S_DONE} state_t;

  state_t                          state_q;
  logic [IMG*IMG*DW-1:0]           img_q;
  logic [NF1*9*DW-1:0]             w1_q;
  logic [NF1*NF2*9*DW-1:0]         w2_q;
  logic [NF1*O1*O1*DW-1:0]         l1_q;
  logic [NM2*O2*O2*DW-1:0]         out_q;
  logic [MW-1:0]                   map_q;
  logic [RW-1:0]                   row_q, col_q;
  logic                            busy_q, done_q;

  logic                            in_l1;
  logic                            col_last, row_last, map_last;
  logic [DW-1:0]                   pix_d, wt_d;
  logic signed [ACCW-1:0]          px_s, wt_s, acc_d;
  logic signed [ACCW:0]            acc_x, shr_x;
  logic [DW-1:0]                   q_d;

  assign in_l1    = (state_q == S_L1);
  assign col_last = (col_q == (in_l1 ? O1_LAST : O2_LAST));
  assign row_last = (row_q == (in_l1 ? O1_LAST : O2_LAST));
  assign map_last = (map_q == (in_l1 ? M1_LAST : M2_LAST));

  // 9-tap window MAC. In L2 the source is the L1 map feeding second-layer map m, which is m/NF2.
  always_comb begin
    acc_d = '0;
    pix_d = '0;
    wt_d  = '0;
    px_s  = '0;
    wt_s  = '0;
    for (int t = 0; t < 9; t++) begin
      if (state_q == S_L2) begin
        pix_d = l1_q[(((int'(map_q) / NF2) * O1 + int'(row_q) + t / 3) * O1
                      + int'(col_q) + t % 3) * DW +: DW];
        wt_d  = w2_q[(int'(map_q) * 9 + t) * DW +: DW];
      end else begin
        pix_d = img_q[((int'(row_q) + t / 3) * IMG + int'(col_q) + t % 3) * DW +: DW];
        wt_d  = w1_q[(int'(map_q) * 9 + t) * DW +: DW];
      end
      px_s  = {{(ACCW-DW){1'b0}}, pix_d};
      wt_s  = {{(ACCW-DW){wt_d[DW-1]}}, wt_d};
      acc_d = acc_d + px_s * wt_s;
    end
  end

  // Requantise: optional rounding bias, arithmetic shift, then clamp to [0, 2^DW-1].
  // The extra bit keeps the rounding add from wrapping at the largest SHIFT.
  always_comb begin
    acc_x = {acc_d[ACCW-1], acc_d};
`ifdef NN_ROUND_EN
    acc_x = acc_x + RND;
`endif
    shr_x = acc_x >>> SHIFT;
    if (shr_x[ACCW])       q_d = '0;
    else if (shr_x > MAXV) q_d = '1;
    else                   q_d = shr_x[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      img_q   <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      l1_q    <= '0;
      out_q   <= '0;
      map_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
          if (start) begin
            img_q   <= in;
            w1_q    <= w1;
            w2_q    <= w2;
            map_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            state_q <= S_ARM;
          end
        end
        // The captured operands settle for one cycle. busy rises on the edge that leaves this state.
        S_ARM: begin
          state_q <= S_L1;
          busy_q  <= 1'b1;
        end
        S_L1, S_L2: begin
          if (in_l1)
            l1_q[((int'(map_q) * O1 + int'(row_q)) * O1 + int'(col_q)) * DW +: DW] <= q_d;
          else
            out_q[((int'(map_q) * O2 + int'(row_q)) * O2 + int'(col_q)) * DW +: DW] <= q_d;
          if (!col_last) begin
            col_q <= col_q + 1'b1;
          end else begin
            col_q <= '0;
            if (!row_last) begin
              row_q <= row_q + 1'b1;
            end else begin
              row_q <= '0;
              if (!map_last) begin
                map_q <= map_q + 1'b1;
              end else begin
                map_q <= '0;
                // L2 follows the last L1 write directly, with no idle cycle in between.
                if (in_l1) begin
                  state_q <= S_L2;
                end else begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_nn_conv2_seq.sv
// Testbench for nn_conv2_seq: table-driven uniform patterns, hand-written corner sequences and random runs.
// It drives two instances in parallel, one with SHIFT=0 and one with SHIFT=1, and checks both against a reference model.
// Inputs are driven and outputs sampled on the falling edge, away from the active edge.
module tb_nn_conv2_seq;
  localparam int IMG = 12, DW = 2, NF1 = 2, NF2 = 2;
  localparam int O1 = IMG - 2, O2 = IMG - 4;
  localparam int INW = IMG * IMG * DW, W1W = NF1 * 9 * DW, W2W = NF1 * NF2 * 9 * DW;
  localparam int OW = NF1 * NF2 * O2 * O2 * DW;
  localparam int N1 = NF1 * O1 * O1, N2 = NF1 * NF2 * O2 * O2;
  localparam int DONE_EDGE = N1 + N2 + 1;
`ifdef NN_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst, start;
  logic [INW-1:0] in_v;
  logic [W1W-1:0] w1_v;
  logic [W2W-1:0] w2_v;
  logic           busy0, done0, busy1, done1;
  logic [OW-1:0]  out0, out1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nn_conv2_seq #(.IMG(IMG), .DW(DW), .NF1(NF1), .NF2(NF2), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .in(in_v), .w1(w1_v), .w2(w2_v),
    .busy(busy0), .done(done0), .out(out0));

  nn_conv2_seq #(.IMG(IMG), .DW(DW), .NF1(NF1), .NF2(NF2), .SHIFT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in(in_v), .w1(w1_v), .w2(w2_v),
    .busy(busy1), .done(done1), .out(out1));

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int rq(input int acc, input int sh);
    int v;
    v = acc;
    if (RND && sh > 0) v = v + (1 << (sh - 1));
    v = v >>> sh;
    if (v < 0) return 0;
    if (v > (1 << DW) - 1) return (1 << DW) - 1;
    return v;
  endfunction

  function automatic logic [OW-1:0] model(input logic [INW-1:0] im, input logic [W1W-1:0] a,
                                          input logic [W2W-1:0] b, input int sh);
    int l1 [NF1][O1][O1];
    int acc;
    logic [OW-1:0] o;
    o = '0;
    for (int f = 0; f < NF1; f++)
      for (int r = 0; r < O1; r++)
        for (int c = 0; c < O1; c++) begin
          acc = 0;
          for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < 3; kc++)
              acc += int'(im[((r + kr) * IMG + c + kc) * DW +: DW])
                   * int'($signed(a[(f * 9 + kr * 3 + kc) * DW +: DW]));
          l1[f][r][c] = rq(acc, sh);
        end
    for (int m = 0; m < NF1 * NF2; m++)
      for (int r = 0; r < O2; r++)
        for (int c = 0; c < O2; c++) begin
          acc = 0;
          for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < 3; kc++)
              acc += l1[m / NF2][r + kr][c + kc]
                   * int'($signed(b[(m * 9 + kr * 3 + kc) * DW +: DW]));
          o[((m * O2 + r) * O2 + c) * DW +: DW] = DW'(rq(acc, sh));
        end
    return o;
  endfunction

  // ---------------- helpers ----------------
  function automatic logic [1023:0] fill(input logic [DW-1:0] v);
    logic [1023:0] f;
    for (int i = 0; i < 1024 / DW; i++) f[i * DW +: DW] = v;
    return f;
  endfunction

  function automatic logic [1023:0] rbits();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[i * 32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_out(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    int bad, first;
    bad = 0;
    first = -1;
    for (int p = 0; p < OW / DW; p++)
      if (act[p * DW +: DW] !== exp[p * DW +: DW]) begin
        bad++;
        if (first < 0) first = p;
      end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d pixels differ; first at index %0d got %0d, expected %0d",
               name, bad, first, act[first * DW +: DW], exp[first * DW +: DW]);
    end
  endtask

  // Starts a run at the current falling edge. Returns after the acceptance edge with the inputs scrambled.
  task automatic start_run(input string name, input logic [INW-1:0] im,
                           input logic [W1W-1:0] a, input logic [W2W-1:0] b);
    in_v  = im;
    w1_v  = a;
    w2_v  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_v  = INW'(rbits());
    w1_v  = W1W'(rbits());
    w2_v  = W2W'(rbits());
    check({name, " busy low in arm cycle"}, int'(busy0), 0);
  endtask

  // Counts edges after acceptance until done. A timeout counts as a failed comparison.
  task automatic wait_done(input string name, output int n);
    n = 0;
    for (int k = 1; k <= 3 * DONE_EDGE; k++) begin
      @(negedge clk);
      if (k == 1) check({name, " busy after first edge"}, int'(busy0), 1);
      if (done0) begin
        n = k;
        break;
      end
    end
    if (n == 0) check({name, " done timeout"}, 0, 1);
  endtask

  task automatic finish_checks(input string name, input int n,
                               input logic [OW-1:0] e0, input logic [OW-1:0] e1);
    check({name, " done edge"}, n, DONE_EDGE);
    check({name, " busy low in done"}, int'(busy0), 0);
    check({name, " done on shift1"}, int'(done1), 1);
    cmp_out({name, " out shift0"}, out0, e0);
    cmp_out({name, " out shift1"}, out1, e1);
  endtask

  task automatic run(input string name, input logic [INW-1:0] im,
                     input logic [W1W-1:0] a, input logic [W2W-1:0] b);
    logic [OW-1:0] e0, e1;
    int n;
    e0 = model(im, a, b, 0);
    e1 = model(im, a, b, 1);
    @(negedge clk);
    start_run(name, im, a, b);
    wait_done(name, n);
    finish_checks(name, n, e0, e1);
    @(negedge clk);
    check({name, " done single cycle"}, int'(done0), 0);
  endtask

  typedef struct {
    logic [DW-1:0] pix;
    logic [DW-1:0] wa;
    logic [DW-1:0] wb;
    int            exp;
  } vec_t;

  initial begin
    vec_t tbl [9];
    logic [INW-1:0] im;
    logic [W1W-1:0] a;
    logic [W2W-1:0] b;
    logic [OW-1:0]  e, ea, eb1, eb0;
    int n, ndone, first_at;

    // Uniform fills: pixel value, w1 tap, w2 tap, and the expected uniform SHIFT=0 output.
    tbl[0] = '{2'd1, 2'd1, 2'd1, 3};  // 9 -> 3, then 27 -> 3
    tbl[1] = '{2'd3, 2'd3, 2'd1, 0};  // w1 = -1, so L1 clamps to 0
    tbl[2] = '{2'd3, 2'd1, 2'd2, 0};  // w2 = -2, so L2 clamps to 0
    tbl[3] = '{2'd0, 2'd1, 2'd1, 0};
    tbl[4] = '{2'd1, 2'd1, 2'd3, 0};  // -27 -> 0
    tbl[5] = '{2'd2, 2'd1, 2'd1, 3};  // 18 -> 3
    tbl[6] = '{2'd1, 2'd0, 2'd1, 0};
    tbl[7] = '{2'd3, 2'd2, 2'd2, 0};
    tbl[8] = '{2'd1, 2'd1, 2'd0, 0};

    // Reset is held with start high. It must win over start.
    rst = 1'b1; start = 1'b1;
    in_v = INW'(fill(2'd1)); w1_v = W1W'(fill(2'd1)); w2_v = W2W'(fill(2'd1));
    repeat (2) @(negedge clk);
    check("reset busy", int'(busy0), 0);
    check("reset done", int'(done0), 0);
    cmp_out("reset out shift0", out0, '0);
    cmp_out("reset out shift1", out1, '0);
    rst = 1'b0; start = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run($sformatf("table%0d", i), INW'(fill(tbl[i].pix)), W1W'(fill(tbl[i].wa)),
          W2W'(fill(tbl[i].wb)));
      cmp_out($sformatf("table%0d hand out", i), out0, OW'(fill(DW'(tbl[i].exp))));
    end

    // Impulse and channel isolation. With SHIFT=1, this is also the rounding case.
    im = '0; im[(5 * IMG + 5) * DW +: DW] = 2'd3;
    a = '0;
    for (int f = 0; f < NF1; f++) a[(f * 9 + 4) * DW +: DW] = 2'd1;
    b = '0; b[4 * DW +: DW] = 2'd1;
    run("impulse", im, a, b);
    e = '0; e[((0 * O2 + 3) * O2 + 3) * DW +: DW] = 2'd3;
    cmp_out("impulse hand shift0", out0, e);
    check("rounding map0(3,3)", int'(out1[((0 * O2 + 3) * O2 + 3) * DW +: DW]), RND ? 1 : 0);

    for (int i = 0; i < 3; i++)
      run($sformatf("random%0d", i), INW'(rbits()), W1W'(rbits()), W2W'(rbits()));

    // A start while busy is ignored. Exactly one done is expected, after edge 457.
    @(negedge clk);
    im = INW'(fill(2'd1)); a = W1W'(fill(2'd1)); b = W2W'(fill(2'd1));
    start_run("handshake", im, a, b);
    ndone = 0; first_at = 0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      start = (k == 99);
      if (done0) begin
        ndone++;
        if (first_at == 0) first_at = k;
      end
    end
    start = 1'b0;
    check("handshake done count", ndone, 1);
    check("handshake done edge", first_at, DONE_EDGE);
    cmp_out("handshake out", out0, OW'(fill(2'd3)));

    // Abort with rst in the middle of L2, then run again.
    @(negedge clk);
    start_run("abort", INW'(rbits()), W1W'(rbits()), W2W'(rbits()));
    repeat (299) @(negedge clk);
    check("abort busy before rst", int'(busy0), 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", int'(busy0), 0);
    cmp_out("abort out shift0", out0, '0);
    cmp_out("abort out shift1", out1, '0);
    rst = 1'b0;
    run("post-abort", INW'(rbits()), W1W'(rbits()), W2W'(rbits()));

    // Back-to-back: start is raised during the done cycle.
    im = INW'(rbits()); a = W1W'(rbits()); b = W2W'(rbits());
    ea = model(im, a, b, 0);
    @(negedge clk);
    start_run("b2b-a", im, a, b);
    wait_done("b2b-a", n);
    finish_checks("b2b-a", n, ea, model(im, a, b, 1));
    im = INW'(rbits()); a = W1W'(rbits()); b = W2W'(rbits());
    eb0 = model(im, a, b, 0);
    eb1 = model(im, a, b, 1);
    start_run("b2b-b", im, a, b);
    wait_done("b2b-b", n);
    finish_checks("b2b-b", n, eb0, eb1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
